load_store_buffer: RTL
======================

Name: load_store_buffer

Overview:
- Consumes the address unit's output: effective address, op, ROB tag and store data.
- Queues up to DEPTH memory requests in program order.
- Executes each request in turn against the byte-wide memory port.
- Broadcasts completion (load data, or store-done) with the ROB tag back to the ROB.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  system clock; all state on posedge
rst  in  1  reset, asynchronous, active-low (0 = reset)
addr  in  32  effective address from address unit
op  in  5  memory op code (encodings in package)
rob_number  in  3  ROB tag; 0 = no request this cycle
ls_value  in  32  store data (don't-care for loads)
full  out  1  stall to upstream
commit_valid  in  1  ROB commits a store this cycle
commit_rob  in  3  tag of committed store
mem_din  in  8  memory read byte, valid 1 cycle after its address
mem_dout  out  8  memory write byte
mem_a  out  32  memory byte address
mem_wr  out  1  1 = write mem_dout to mem_a this cycle
result_valid  out  1  one-cycle completion pulse
result_rob  out  3  tag of completed request
result_value  out  32  load data, extended per op; 0 for stores

Behaviour:
- Reset (rst=0, async): FIFO empty, all commit flags cleared, FSM=IDLE. Outputs reset to: full=0, mem_wr=0, mem_a=0, mem_dout=0, result_valid=0, result_rob=0, result_value=0.
- Reset mid-access aborts the access. mem_wr drops with reset, not at the next edge.
- Enqueue: on posedge, when rob_number!=0, op[4]=1 and count<DEPTH, write {addr, op, rob_number, ls_value, committed=0} at tail.
- op[4]=0 is not a memory op and is ignored.
- An enqueue at count==DEPTH is dropped with no state change; the bench flags it as an error.
- full: asserted when count ≥ DEPTH-1. The spare slot absorbs the one request already in flight in the address unit.
- Commit: when commit_valid, set committed on every valid entry whose tag equals commit_rob.
  - Enqueue and commit with the same tag in the same cycle: the new entry is enqueued with committed=1.
- Byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW. Bytes are little-endian at addr+0..N-1. No alignment check; the address is a 32-bit add that wraps.
- IDLE:
  - head valid and a load → ACCESS, idx=0.
  - head valid, store, committed → ACCESS.
  - head valid, store, uncommitted → WAIT_COMMIT.
  - empty → stay in IDLE.
- WAIT_COMMIT: hold, mem_wr=0; go to ACCESS on the cycle after the head's committed flag is set.
- ACCESS, load (N+1 cycles):
  - For idx<N, drive mem_a=addr+idx, mem_wr=0.
  - For idx≥1, capture mem_din into byte idx-1.
  - At idx==N, capture the last byte, then go to DONE.
- ACCESS, store (N cycles):
  - Drive mem_a=addr+idx, mem_dout=ls_value byte idx, mem_wr=1.
  - After idx==N-1, go to DONE.
- DONE (1 cycle): result_valid=1, result_rob=head tag, result_value set per op:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: raw word.
  - stores: 0.
  - Pop the head and return to IDLE. result_valid is 0 in every other state.
- mem_wr=0 in every state other than store ACCESS.
- Pop and enqueue in the same cycle are both honoured; count is unchanged.
- Pointers wrap modulo DEPTH.
- Latency, load entering IDLE at cycle t with an empty queue: result_valid at t+N+2.

Decomposition:
- Package ls_pkg:
  - Op encodings: LB=5'h10, LH=5'h11, LW=5'h12, LBU=5'h13, LHU=5'h14, SB=5'h18, SH=5'h19, SW=5'h1A.
  - FSM state enum: IDLE, WAIT_COMMIT, ACCESS, DONE.
  - Entry struct and a byte-count function.
- One sub-module, lsb_fifo: storage, head/tail pointers, count, per-entry commit flags, commit tag match.
- The top level holds the FSM, byte sequencing and extension logic.

Test Plan:
- LW, addr=0x100, tag 3, memory bytes 0x11,0x22,0x33,0x44 → mem_a 0x100..0x103 on consecutive cycles; one result_valid pulse, rob 3, value 0x44332211.
- LB, addr 0x200 holding 0x80, tag 1 → value 0xFFFFFF80. LBU on the same address → 0x00000080.
- SH, addr=0x300, ls_value=0xABCD, tag 2, no commit → mem_wr stays 0 for 10 cycles. Raise commit_valid/commit_rob=2 → writes 0xCD@0x300 then 0xAB@0x301, then result_valid with rob 2, value 0.
- Enqueue 4 back-to-back loads while the first is in ACCESS → full rises at count 3. Results come out in enqueue order, one pulse each, with no lost or duplicated tags.
- Reset asserted mid-SW after 2 bytes → mem_wr falls immediately, queue empty after release, no result_valid pulse.
- rob_number=0, or op=5'h03 with a nonzero tag → nothing enqueued, count stays 0.

Source files
------------

// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared types, op encodings and helpers for the load/store buffer
// Purpose: op codes, FSM state enum, queue entry struct, byte-count and
//          load-extension helpers. No ports.
package ls_pkg;

   localparam logic [4:0] OP_LB  = 5'h10;
   localparam logic [4:0] OP_LH  = 5'h11;
   localparam logic [4:0] OP_LW  = 5'h12;
   localparam logic [4:0] OP_LBU = 5'h13;
   localparam logic [4:0] OP_LHU = 5'h14;
   localparam logic [4:0] OP_SB  = 5'h18;
   localparam logic [4:0] OP_SH  = 5'h19;
   localparam logic [4:0] OP_SW  = 5'h1A;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_COMMIT = 2'd1,
      ACCESS      = 2'd2,
      DONE        = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [4:0]  op;
      logic [2:0]  rob;
      logic [31:0] value;
   } entry_t;

   function automatic logic [2:0] byte_count(input logic [4:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 3'd1;
         OP_LH, OP_LHU, OP_SH: return 3'd2;
         default:              return 3'd4;
      endcase
   endfunction

   // All store encodings have bit 3 set; no load encoding does.
   function automatic logic is_store(input logic [4:0] op);
      return op[3];
   endfunction

   function automatic logic [31:0] load_extend(input logic [4:0] op, input logic [31:0] d);
      case (op)
         OP_LB:   return {{24{d[7]}}, d[7:0]};
         OP_LH:   return {{16{d[15]}}, d[15:0]};
         OP_LBU:  return {24'h0, d[7:0]};
         OP_LHU:  return {16'h0, d[15:0]};
         OP_LW:   return d;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/lsb_fifo.sv
// rtl/lsb_fifo.sv - in-order request queue with per-entry commit flags
// Purpose: stores memory requests in program order and tracks which stores
//          the ROB has committed.
// Ports: clk, rst (async active-low); i_enq/i_enq_entry push a request;
//        i_commit_valid/i_commit_rob mark matching entries committed;
//        i_pop retires the head; o_head*/o_full describe queue state.
module lsb_fifo
   import ls_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_enq,
   input  entry_t     i_enq_entry,
   input  logic       i_commit_valid,
   input  logic [2:0] i_commit_rob,
   input  logic       i_pop,
   output logic       o_head_valid,
   output entry_t     o_head,
   output logic       o_head_committed,
   output logic       o_full
);

   entry_t             r_mem [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [DEPTH-1:0]   r_committed;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [PTR_W:0]     r_count;
   logic               w_enq;
   logic               w_pop;

   // A push into a completely full queue is dropped outright.
   assign w_enq = i_enq && (r_count != (PTR_W+1)'(DEPTH));
   assign w_pop = i_pop && r_valid[r_head];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid     <= '0;
         r_committed <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + 1'b1;
         if (w_pop) r_head <= r_head + 1'b1;
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         for (int i = 0; i < DEPTH; i++) begin
            if (i_commit_valid && r_valid[i] && (r_mem[i].rob == i_commit_rob))
               r_committed[i] <= 1'b1;
         end
         if (w_pop) begin
            r_valid[r_head]     <= 1'b0;
            r_committed[r_head] <= 1'b0;
         end
         // A commit arriving alongside its own enqueue must not be lost.
         if (w_enq) begin
            r_valid[r_tail]     <= 1'b1;
            r_committed[r_tail] <= i_commit_valid && (i_enq_entry.rob == i_commit_rob);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_tail] <= i_enq_entry;
   end

   assign o_head_valid     = r_valid[r_head];
   assign o_head           = r_mem[r_head];
   assign o_head_committed = r_committed[r_head];
   // One spare slot absorbs the request already in flight upstream.
   assign o_full           = (r_count >= (PTR_W+1)'(DEPTH-1));

endmodule

// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - in-order load/store buffer over a byte-wide memory port
// Purpose: queues address-unit requests, runs them one byte per cycle against
//          memory, and reports completion with the ROB tag.
// Ports: clk, rst (async active-low); addr/op/rob_number/ls_value request in;
//        full stall out; commit_valid/commit_rob store commit in;
//        mem_din/mem_dout/mem_a/mem_wr memory port;
//        result_valid/result_rob/result_value completion out.
module load_store_buffer
   import ls_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [4:0]  op,
   input  logic [2:0]  rob_number,
   input  logic [31:0] ls_value,
   output logic        full,
   input  logic        commit_valid,
   input  logic [2:0]  commit_rob,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic        result_valid,
   output logic [2:0]  result_rob,
   output logic [31:0] result_value
);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_idx;
   logic [31:0] r_data;
   entry_t      w_head;
   logic        w_head_valid;
   logic        w_head_committed;
   logic        w_store;
   logic        w_pop;
   logic [2:0]  w_n;
   logic [31:0] w_byte_addr;

   lsb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk              (clk),
      .rst              (rst),
      .i_enq            ((rob_number != 3'd0) && op[4]),
      .i_enq_entry      ('{addr: addr, op: op, rob: rob_number, value: ls_value}),
      .i_commit_valid   (commit_valid),
      .i_commit_rob     (commit_rob),
      .i_pop            (w_pop),
      .o_head_valid     (w_head_valid),
      .o_head           (w_head),
      .o_head_committed (w_head_committed),
      .o_full           (full)
   );

   assign w_store     = is_store(w_head.op);
   assign w_n         = byte_count(w_head.op);
   assign w_byte_addr = w_head.addr + {29'h0, r_idx};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Memory outputs are decoded from state so reset drops mem_wr at once.
   always_comb begin
      w_next       = r_state;
      w_pop        = 1'b0;
      mem_a        = 32'h0;
      mem_dout     = 8'h0;
      mem_wr       = 1'b0;
      result_valid = 1'b0;
      result_rob   = 3'd0;
      result_value = 32'h0;
      case (r_state)
         IDLE: begin
            if (w_head_valid)
               w_next = (!w_store || w_head_committed) ? ACCESS : WAIT_COMMIT;
         end
         WAIT_COMMIT: begin
            if (w_head_committed) w_next = ACCESS;
         end
         ACCESS: begin
            if (w_store) begin
               mem_a  = w_byte_addr;
               mem_wr = 1'b1;
               case (r_idx[1:0])
                  2'd0:    mem_dout = w_head.value[7:0];
                  2'd1:    mem_dout = w_head.value[15:8];
                  2'd2:    mem_dout = w_head.value[23:16];
                  default: mem_dout = w_head.value[31:24];
               endcase
               if (r_idx == w_n - 3'd1) w_next = DONE;
            end else begin
               // Loads spend one extra cycle collecting the final byte.
               if (r_idx < w_n) mem_a = w_byte_addr;
               if (r_idx == w_n) w_next = DONE;
            end
         end
         DONE: begin
            result_valid = 1'b1;
            result_rob   = w_head.rob;
            result_value = w_store ? 32'h0 : load_extend(w_head.op, r_data);
            w_pop        = 1'b1;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Read data arrives one cycle after its address, so byte idx-1 lands at idx.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx  <= 3'd0;
         r_data <= 32'h0;
      end else if (r_state == ACCESS) begin
         r_idx <= r_idx + 3'd1;
         if (!w_store) begin
            case (r_idx)
               3'd1:    r_data[7:0]   <= mem_din;
               3'd2:    r_data[15:8]  <= mem_din;
               3'd3:    r_data[23:16] <= mem_din;
               3'd4:    r_data[31:24] <= mem_din;
               default: r_data        <= r_data;
            endcase
         end
      end else begin
         r_idx <= 3'd0;
      end
   end

endmodule
